// File: rtl/pipe_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mag_comp
//  Purpose  : Pipelined WIDTH-bit magnitude comparator. Resolves CHUNK bits
//             per stage, MSB chunk first, one transaction per cycle. Supports
//             a per-transaction signed/unsigned mode and valid/ready flow
//             control on both sides with full backpressure.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   transaction present on a/b/e/sgn
//    in_ready   out  block accepts a transaction this cycle
//    a, b       in   WIDTH-bit operands
//    e          in   compare enable, travels with the transaction
//    sgn        in   1 = two's-complement compare, 0 = unsigned
//    out_valid  out  result present on lt/eq/gt (registered)
//    out_ready  in   consumer takes the result this cycle
//    lt/eq/gt   out  registered compare flags
//  WIDTH must be a multiple of CHUNK and give at least two stages.
// ============================================================================
module pipe_mag_comp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             r_out_valid;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic             w_advance;
    logic [WIDTH-1:0] w_sign_mask;

    // One global advance: the whole pipe moves unless a result is parked
    // at the output and the consumer is not taking it.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign w_sign_mask = {sgn, {(WIDTH-1){1'b0}}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage k sees the operand bits from chunk k downward.
        localparam int IN_W  = WIDTH - k * CHUNK;
        localparam int REM_W = IN_W - CHUNK;

        logic            w_v_in;
        logic            w_e_in;
        logic            w_dec_in;
        logic            w_dir_in;
        logic [IN_W-1:0] w_a_in;
        logic [IN_W-1:0] w_b_in;
        logic [CHUNK-1:0] w_ca;
        logic [CHUNK-1:0] w_cb;

        logic            r_v;
        logic            r_e;
        logic            r_dec;
        logic            r_dir;

        if (k == 0) begin : g_src
            assign w_v_in   = in_valid;
            assign w_e_in   = e;
            assign w_dec_in = 1'b0;
            assign w_dir_in = 1'b0;
            assign w_a_in   = a ^ w_sign_mask;
            assign w_b_in   = b ^ w_sign_mask;
        end else begin : g_src
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_e_in   = g_stage[k-1].r_e;
            assign w_dec_in = g_stage[k-1].r_dec;
            assign w_dir_in = g_stage[k-1].r_dir;
            assign w_a_in   = g_stage[k-1].g_rem.r_a_rem;
            assign w_b_in   = g_stage[k-1].g_rem.r_b_rem;
        end

        assign w_ca = w_a_in[IN_W-1 -: CHUNK];
        assign w_cb = w_b_in[IN_W-1 -: CHUNK];

        // The first differing chunk (from the top) fixes the outcome; later
        // stages only carry it along.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_e   <= 1'b0;
                r_dec <= 1'b0;
                r_dir <= 1'b0;
            end else if (w_advance) begin
                r_v   <= w_v_in;
                r_e   <= w_e_in;
                r_dec <= w_dec_in || (w_ca != w_cb);
                r_dir <= w_dec_in ? w_dir_in : (w_ca > w_cb);
            end
        end

        // Lower, not-yet-examined bits; the last stage has none left.
        if (k < STAGES - 1) begin : g_rem
            logic [REM_W-1:0] r_a_rem;
            logic [REM_W-1:0] r_b_rem;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_rem <= '0;
                    r_b_rem <= '0;
                end else if (w_advance) begin
                    r_a_rem <= w_a_in[REM_W-1:0];
                    r_b_rem <= w_b_in[REM_W-1:0];
                end
            end
        end
    end

    logic w_last_v;
    logic w_last_e;
    logic w_last_dec;
    logic w_last_dir;
    logic w_flag_en;

    assign w_last_v   = g_stage[STAGES-1].r_v;
    assign w_last_e   = g_stage[STAGES-1].r_e;
    assign w_last_dec = g_stage[STAGES-1].r_dec;
    assign w_last_dir = g_stage[STAGES-1].r_dir;
    // Flags only light for a valid, enabled transaction; a disabled one
    // still produces out_valid with all flags low.
    assign w_flag_en  = w_last_v && w_last_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_last_v;
            r_lt        <= w_flag_en &&  w_last_dec && !w_last_dir;
            r_eq        <= w_flag_en && !w_last_dec;
            r_gt        <= w_flag_en &&  w_last_dec &&  w_last_dir;
        end
    end

    assign out_valid = r_out_valid;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_mag_comp
//  Purpose  : Self-checking bench for pipe_mag_comp (WIDTH=16, CHUNK=4).
//             Reference: integer compare of the operands plus a queue of
//             in-flight transactions aged by advancing clock edges.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_mag_comp;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             e = 1'b0;
    logic             sgn = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             lt;
    logic             eq;
    logic             gt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_mag_comp #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .e         (e),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int       age;
        logic [2:0] f;   // {lt, eq, gt}
    } item_t;

    item_t q[$];

    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic en, input logic s);
        longint xv;
        longint yv;
        if (!en) return 3'b000;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        if (xv < yv)  return 3'b100;
        if (xv == yv) return 3'b010;
        return 3'b001;
    endfunction

    // A transaction is visible at the output once it has seen STAGES
    // advancing edges after the one that accepted it.
    function automatic logic model_ov();
        foreach (q[i]) if (q[i].age == STAGES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_f();
        foreach (q[i]) if (q[i].age == STAGES) return q[i].f;
        return 3'b000;
    endfunction

    task automatic drive(input logic iv, input logic [WIDTH-1:0] ia,
                         input logic [WIDTH-1:0] ib, input logic ie,
                         input logic is, input logic ior);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        e         = ie;
        sgn       = is;
        out_ready = ior;
        #1;
    endtask

    task automatic tick();
        logic adv;
        logic acc;
        logic [2:0] f;
        adv = !model_ov() || out_ready;
        acc = in_valid && adv;
        f   = ref_cmp(a, b, e, sgn);
        @(posedge clk);
        if (adv) begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > STAGES) void'(q.pop_front());
            if (acc) q.push_back('{age: 0, f: f});
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if ({lt, eq, gt} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {lt, eq, gt}); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_eq_latency();
        drive(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
        tick();
        for (int c = 1; c <= STAGES + 1; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (out_valid !== (c == STAGES))
                begin errors++; $display("FAIL lat_out_valid edge+%0d: got %b want %b", c, out_valid, (c == STAGES)); end
            if (c == STAGES) begin
                checks++;
                if ({lt, eq, gt} !== 3'b010) begin errors++; $display("FAIL lat_eq_flags: got %b want 010", {lt, eq, gt}); end
            end
        end
    endtask

    task automatic test_mode();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic             vs [4];
        logic [2:0]       vx [4];
        int k;
        va = '{16'h8000, 16'h8000, 16'h0000, 16'hF000};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0FFF};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0};
        vx = '{3'b001, 3'b100, 3'b100, 3'b001};
        k = 0;
        for (int i = 0; i < 4 + STAGES + 2; i++) begin
            if (i < 4) drive(1'b1, va[i], vb[i], 1'b1, vs[i], 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL mode_in_ready cyc %0d: got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== model_ov())
                begin errors++; $display("FAIL mode_out_valid cyc %0d: got %b want %b", i, out_valid, model_ov()); end
            if (out_valid === 1'b1 && k < 4) begin
                checks++;
                if ({lt, eq, gt} !== vx[k])
                    begin errors++; $display("FAIL mode_flags vec %0d: got %b want %b", k, {lt, eq, gt}, vx[k]); end
                k++;
            end
        end
        checks++;
        if (k !== 4) begin errors++; $display("FAIL mode_count: got %0d want 4", k); end
    endtask

    task automatic test_enable_off();
        logic [WIDTH-1:0] va [2];
        logic [WIDTH-1:0] vb [2];
        logic             ve [2];
        logic [2:0]       vx [2];
        int k;
        va = '{16'd5, 16'd3};
        vb = '{16'd3, 16'd5};
        ve = '{1'b0, 1'b1};
        vx = '{3'b000, 3'b100};
        k = 0;
        for (int i = 0; i < 2 + STAGES + 2; i++) begin
            if (i < 2) drive(1'b1, va[i], vb[i], ve[i], 1'b0, 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (out_valid !== (i >= STAGES && i < STAGES + 2))
                begin errors++; $display("FAIL en_out_valid cyc %0d: got %b want %b", i, out_valid, (i >= STAGES && i < STAGES + 2)); end
            if (out_valid === 1'b1 && k < 2) begin
                checks++;
                if ({lt, eq, gt} !== vx[k])
                    begin errors++; $display("FAIL en_flags vec %0d: got %b want %b", k, {lt, eq, gt}, vx[k]); end
                k++;
            end
        end
        checks++;
        if (k !== 2) begin errors++; $display("FAIL en_count: got %0d want 2", k); end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        for (int i = 0; i < 8 + STAGES + 2; i++) begin
            ra = 16'($urandom());
            rb = (i % 3 == 0) ? (ra ^ 16'($urandom_range(0, 15))) : 16'($urandom());
            if (i < 8) drive(1'b1, ra, rb, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d: got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== (i >= STAGES && i < STAGES + 8))
                begin errors++; $display("FAIL stream_out_valid cyc %0d: got %b want %b", i, out_valid, (i >= STAGES && i < STAGES + 8)); end
            if (model_ov()) begin
                checks++;
                if ({lt, eq, gt} !== model_f())
                    begin errors++; $display("FAIL stream_flags cyc %0d: got %b want %b", i, {lt, eq, gt}, model_f()); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        int   drn;
        logic iv;
        logic ordy;
        logic exp_rdy;
        acc = 0;
        drn = 0;
        for (int i = 0; i < 10 + STAGES + 8; i++) begin
            iv   = (i < 10);
            ordy = !(i >= 5 && i < 8);
            drive(iv, 16'($urandom()), 16'($urandom()), 1'b1, 1'($urandom_range(0, 1)), ordy);
            exp_rdy = !model_ov() || ordy;
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", i, in_ready, exp_rdy); end
            if (!ordy) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cyc %0d: got %b want 0", i, in_ready); end
            end
            if (iv && exp_rdy) acc++;
            if (out_valid === 1'b1 && ordy) drn++;
            tick();
            checks++;
            if (out_valid !== model_ov())
                begin errors++; $display("FAIL bp_out_valid cyc %0d: got %b want %b", i, out_valid, model_ov()); end
            if (model_ov()) begin
                checks++;
                if ({lt, eq, gt} !== model_f())
                    begin errors++; $display("FAIL bp_flags cyc %0d: got %b want %b", i, {lt, eq, gt}, model_f()); end
            end
        end
        checks++;
        if (acc !== 7) begin errors++; $display("FAIL bp_accepts: got %0d want 7", acc); end
        checks++;
        if (drn !== acc) begin errors++; $display("FAIL bp_drains: got %0d want %0d", drn, acc); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'b1, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        checks++;
        if (out_valid !== model_ov())
            begin errors++; $display("FAIL rst_pre_valid: got %b want %b", out_valid, model_ov()); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        checks++;
        if ({lt, eq, gt} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b want 000", {lt, eq, gt}); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < STAGES + 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready cyc %0d: got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc %0d: got %b want 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_eq_latency();
        test_mode();
        test_enable_off();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
